hann_fft_frame_sequencer: RTL

- Ping-pong frame controller for the Hann-window → FFT sample buffer (16-bit data, ADDR_W-bit address, dual-port).
- Splits the buffer into two banks, each FRAME_LEN = 2^(ADDR_W-1) samples. Bank index is the address MSB.
- Write side: steers the windowed sample stream into the free bank through the buffer's memwriter port.
- Read side: hands completed frames to the FFT, maps its read index onto the memreader port, and frees a bank when the FFT reports done.

---
 rtl/hann_fft_frame_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hann_fft_frame_sequencer.sv
// Ping-pong frame controller between the Hann window stream and the FFT sample buffer.
// Optional drop counter/sticky flag enabled by defining HANN_FFT_SEQ_OVERRUN_CNT_EN.
module hann_fft_frame_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] memwriter_data,
  output logic [ADDR_W-1:0] memwriter_addr,
  output logic              memwriter_valid,
  input  logic [ADDR_W-2:0] fft_rd_idx,
  output logic [ADDR_W-1:0] memreader_addr,
  output logic              frame_valid,
  output logic              frame_bank,
  input  logic              fft_done
`ifdef HANN_FFT_SEQ_OVERRUN_CNT_EN
  ,
  output logic [15:0]       overrun_cnt,
  output logic              overrun_sticky
`endif
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_st_e;
  typedef enum logic {W_WRITE, W_WAIT} wr_st_e;
  typedef enum logic {R_IDLE, R_BUSY} rd_st_e;

  bank_st_e          bank_q [2];
  bank_st_e          bank_d [2];
  wr_st_e            wr_st_q;
  rd_st_e            rd_st_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic              in_ready_q;
  logic              frame_valid_q;
  logic              mw_valid_q;
  logic [ADDR_W-1:0] mw_addr_q;
  logic [DATA_W-1:0] mw_data_q;

  logic wr_other;
  logic accept;
  logic last_accept;
  logic release_rd;
  logic start_rd;
  logic other_free;
  logic wait_resume;

  assign wr_other    = ~wr_bank_q;
  assign accept      = in_valid & in_ready_q;
  assign last_accept = accept && (wr_idx_q == LAST_IDX);
  assign release_rd  = (rd_st_q == R_BUSY) && fft_done;
  assign start_rd    = (rd_st_q == R_IDLE) && (bank_q[rd_bank_q] == B_FULL);
  // A bank released by the FFT in this very cycle counts as free, so the writer never bubbles.
  assign other_free  = (bank_q[wr_other] == B_FREE) || (release_rd && (rd_bank_q == wr_other));
  assign wait_resume = (wr_st_q == W_WAIT) && (bank_q[wr_other] == B_FREE);

  // Writer updates are applied last: a bank freed and re-claimed in one cycle ends up FILLING.
  always_comb begin
    bank_d = bank_q;
    if (start_rd)   bank_d[rd_bank_q] = B_READING;
    if (release_rd) bank_d[rd_bank_q] = B_FREE;
    if (last_accept) begin
      bank_d[wr_bank_q] = B_FULL;
      if (other_free) bank_d[wr_other] = B_FILLING;
    end
    if (wait_resume) bank_d[wr_other] = B_FILLING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]     <= B_FILLING;
      bank_q[1]     <= B_FREE;
      wr_st_q       <= W_WRITE;
      rd_st_q       <= R_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      in_ready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
      mw_valid_q    <= 1'b0;
      mw_addr_q     <= '0;
      mw_data_q     <= '0;
    end else begin
      bank_q     <= bank_d;
      mw_valid_q <= accept;
      if (accept) begin
        mw_addr_q <= {wr_bank_q, wr_idx_q};
        mw_data_q <= in_data;
        wr_idx_q  <= wr_idx_q + IDX_ONE;
      end
      if (last_accept) begin
        if (other_free) begin
          wr_bank_q <= wr_other;
        end else begin
          wr_st_q    <= W_WAIT;
          in_ready_q <= 1'b0;
        end
      end
      if (wait_resume) begin
        wr_bank_q  <= wr_other;
        wr_st_q    <= W_WRITE;
        in_ready_q <= 1'b1;
      end

      if (rd_st_q == R_IDLE) begin
        if (start_rd) begin
          rd_st_q       <= R_BUSY;
          frame_valid_q <= 1'b1;
        end
      end else if (fft_done) begin
        rd_st_q       <= R_IDLE;
        frame_valid_q <= 1'b0;
        rd_bank_q     <= ~rd_bank_q;
      end
    end
  end

  assign in_ready        = in_ready_q;
  assign memwriter_valid = mw_valid_q;
  assign memwriter_addr  = mw_addr_q;
  assign memwriter_data  = mw_data_q;
  assign frame_valid     = frame_valid_q;
  assign frame_bank      = rd_bank_q;
  assign memreader_addr  = {rd_bank_q, fft_rd_idx};

`ifdef HANN_FFT_SEQ_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q;
  logic        ovr_sticky_q;
  logic        drop;

  assign drop = in_valid & ~in_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt_q    <= '0;
      ovr_sticky_q <= 1'b0;
    end else if (drop) begin
      if (ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
      ovr_sticky_q <= 1'b1;
    end
  end

  assign overrun_cnt    = ovr_cnt_q;
  assign overrun_sticky = ovr_sticky_q;
`endif

endmodule
